// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and default sizing for the slice-serial adder/subtractor.
package serial_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SLICE = 4;

endpackage

// File: rtl/serial_add_sequencer_adder_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB
// so the sequencer can derive signed overflow on the final slice.
module adder_slice
    import serial_add_sequencer_pkg::*;
#(
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout  = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/serial_add_sequencer.sv
// Slice-serial adder/subtractor: captures operands, adds SLICE bits per cycle
// over WIDTH/SLICE cycles, then holds the result until the consumer takes it.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (SLICE <= 0 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("serial_add_sequencer: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               sub_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   sum_next;
    logic               carry_out_reg;
    logic               overflow_reg;

    logic [SLICE-1:0]   a_slices [N];
    logic [SLICE-1:0]   b_slices [N];
    logic [SLICE-1:0]   slice_a;
    logic [SLICE-1:0]   slice_b;
    logic [SLICE-1:0]   slice_s;
    logic               slice_cout;
    logic               slice_c_msb;
    logic               last_slice;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice_mux
            assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
            assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    // Subtraction is a + ~b + 1; the +1 comes from the carry seeded with sub.
    assign slice_a    = a_slices[idx_reg];
    assign slice_b    = b_slices[idx_reg] ^ {SLICE{sub_reg}};
    assign last_slice = (idx_reg == IDX_W'(N - 1));

    adder_slice #(
        .SLICE (SLICE)
    ) u_adder_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_reg),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_comb begin
        sum_next = sum_reg;
        for (int i = 0; i < N; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sum_next[i*SLICE +: SLICE] = slice_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sub_reg   <= sub;
                        carry_reg <= sub;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= slice_cout;
                    idx_reg   <= idx_reg + 1'b1;
                    if (last_slice) begin
                        carry_out_reg <= slice_cout;
                        overflow_reg  <= slice_cout ^ slice_c_msb;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a result scoreboard queue.
module tb_serial_add_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(
        .WIDTH (32),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width two's-complement arithmetic with 33-bit carry.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] yb;
        logic [W:0]   full;
        res_t         r;
        yb   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, s};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.v  = (x[W-1] == yb[W-1]) && (full[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input int hold, input bit scramble);
        res_t exp_r;
        int   cycles;
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        sb_q.push_back(model(x, y, s));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cycles   = 0;
        while (!out_valid && cycles < 40) begin
            if (scramble) begin
                a        = $urandom;
                b        = $urandom;
                sub      = 1'($urandom);
                in_valid = 1'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        check("latency", 64'(cycles), 64'd8);
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check("sum", {32'd0, sum}, {32'd0, exp_r.s});
        check("carry_out", {63'd0, carry_out}, {63'd0, exp_r.c});
        check("overflow", {63'd0, overflow}, {63'd0, exp_r.v});
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                a        = ~x;
                b        = y + 32'd7;
                sub      = ~s;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_sum", {32'd0, sum}, {32'd0, exp_r.s});
            check("hold_carry_out", {63'd0, carry_out}, {63'd0, exp_r.c});
            check("hold_overflow", {63'd0, overflow}, {63'd0, exp_r.v});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        check("release_out_valid", {63'd0, out_valid}, 64'd0);
        $display("op a=%08h b=%08h sub=%0b -> sum=%08h cout=%0b ovf=%0b cycles=%0d",
                 x, y, s, sum, carry_out, overflow, cycles);
        if (hold > 0) begin
            @(negedge clk);
            check("no_queued_accept", {63'd0, in_ready}, 64'd1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_sum", {32'd0, sum}, 64'd0);
        check("reset_carry_out", {63'd0, carry_out}, 64'd0);
        check("reset_overflow", {63'd0, overflow}, 64'd0);

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        run_op(32'h0000_0003, 32'h0000_0005, 1'b1, 0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0);
        run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 5, 1'b0);

        // Abort mid-operation: reset during the third RUN cycle.
        a        = 32'h0000_1234;
        b        = 32'h0000_5678;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_sum", {32'd0, sum}, 64'd0);
        check("abort_carry_out", {63'd0, carry_out}, 64'd0);
        $display("abort a=00001234 b=00005678 -> in_ready=%0b sum=%08h", in_ready, sum);
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 0, 1'b0);

        run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 0, 1'b1);
        run_op(32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_op($urandom, $urandom, 1'($urandom), 0, 1'b0);
        end

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
